// File: rtl/uart_fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and TX FSM encoding for uart_fifo_io.
package uart_fifo_pkg;

  localparam logic [1:0] RegData    = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegCtrl    = 2'd2;
  localparam logic [1:0] RegRxCount = 2'd3;

  localparam int unsigned StTxOvf = 4;
  localparam int unsigned StRxOvr = 5;

  localparam int unsigned CtrlTxEn    = 0;
  localparam int unsigned CtrlRxFlush = 1;
  localparam int unsigned CtrlRxIrqEn = 2;
  localparam int unsigned CtrlTxIrqEn = 3;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; a pop of an empty FIFO is ignored and a push into a full
// FIFO lands only when a pop retires an entry on the same edge.
module sync_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [Width-1:0]       wdata_i,
  output logic [Width-1:0]       rdata_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FullCnt) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_fifo_io.sv
// Memory-mapped buffered UART port: 4-byte register window, TX/RX FIFOs and TX launch FSM.
// Optional interrupt output and CTRL irq enables when UART_FIFO_IRQ_EN is defined.
module uart_fifo_io
  import uart_fifo_pkg::*;
#(
  parameter int unsigned       Depth    = 16,
  parameter int unsigned       Width    = 8,
  parameter int unsigned       AddrW    = 16,
  parameter logic [AddrW-1:0]  BaseAddr = 16'hFF10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] addr_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [Width-1:0] bus_di_i,
  output logic [Width-1:0] bus_do_o,
  output logic             sel_o,
  output logic [Width-1:0] tx_data_o,
  output logic             tx_wr_o,
  input  logic             tx_done_i,
  input  logic [Width-1:0] rx_data_i,
  input  logic             rx_done_i
`ifdef UART_FIFO_IRQ_EN
  ,
  output logic             irq_o
`endif
);

  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [1:0]       reg_off;
  logic             wr_data, wr_status, wr_ctrl, rd_data;
  logic             tx_pop, rx_flush, tx_busy;
  logic [CntW-1:0]  tx_count, rx_count;
  logic [Width-1:0] tx_head, rx_head;
  logic             tx_empty, tx_full, rx_empty, rx_full;
  logic             tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;
  logic             tx_en_q, tx_en_d;
  logic [3:0]       ctrl_rd;
  tx_state_e        state_q;
  logic [Width-1:0] tx_data_q;
  logic             tx_wr_q;

  assign sel_o     = (addr_i[AddrW-1:2] == BaseAddr[AddrW-1:2]);
  assign reg_off   = addr_i[1:0];
  assign wr_data   = we_i && sel_o && (reg_off == RegData);
  assign wr_status = we_i && sel_o && (reg_off == RegStatus);
  assign wr_ctrl   = we_i && sel_o && (reg_off == RegCtrl);
  assign rd_data   = re_i && sel_o && (reg_off == RegData);
  assign rx_flush  = wr_ctrl && bus_di_i[CtrlRxFlush];
  assign tx_pop    = (state_q == StLoad);
  assign tx_busy   = (state_q != StIdle);

  assign tx_empty = (tx_count == '0);
  assign tx_full  = (tx_count == FullCnt);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FullCnt);

  sync_fifo #(.Depth(Depth), .Width(Width)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (wr_data),
    .pop_i   (tx_pop),
    .flush_i (1'b0),
    .wdata_i (bus_di_i),
    .rdata_o (tx_head),
    .count_o (tx_count)
  );

  sync_fifo #(.Depth(Depth), .Width(Width)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_done_i),
    .pop_i   (rd_data),
    .flush_i (rx_flush),
    .wdata_i (rx_data_i),
    .rdata_o (rx_head),
    .count_o (rx_count)
  );

  // Set beats clear when a drop and a write-1-to-clear coincide.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_ovr_d = rx_ovr_q;
    tx_en_d  = tx_en_q;
    if (wr_status && bus_di_i[StTxOvf]) tx_ovf_d = 1'b0;
    if (wr_status && bus_di_i[StRxOvr]) rx_ovr_d = 1'b0;
    if (wr_data && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_done_i && rx_full && !rd_data && !rx_flush) rx_ovr_d = 1'b1;
    if (wr_ctrl) tx_en_d = bus_di_i[CtrlTxEn];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      tx_en_q  <= 1'b1;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_ovr_q <= rx_ovr_d;
      tx_en_q  <= tx_en_d;
    end
  end

`ifdef UART_FIFO_IRQ_EN
  logic rx_irq_en_q, tx_irq_en_q, irq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        rx_irq_en_q <= bus_di_i[CtrlRxIrqEn];
        tx_irq_en_q <= bus_di_i[CtrlTxIrqEn];
      end
      irq_q <= (rx_irq_en_q && !rx_empty) || (tx_irq_en_q && tx_empty) || tx_ovf_q || rx_ovr_q;
    end
  end

  assign irq_o   = irq_q;
  assign ctrl_rd = {tx_irq_en_q, rx_irq_en_q, 1'b0, tx_en_q};
`else
  assign ctrl_rd = {3'b000, tx_en_q};
`endif

  // rx_flush is a write-only strobe, so CTRL[1] always reads back as 0.
  always_comb begin
    bus_do_o = '0;
    if (sel_o) begin
      case (reg_off)
        RegData:   bus_do_o = rx_empty ? '0 : rx_head;
        RegStatus: bus_do_o = Width'({tx_busy, rx_ovr_q, tx_ovf_q, rx_full, rx_empty,
                                      tx_full, tx_empty});
        RegCtrl:   bus_do_o = Width'(ctrl_rd);
        default:   bus_do_o = Width'(rx_count);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tx_en_q && !tx_empty) begin
            state_q   <= StLoad;
            tx_data_q <= tx_head;
            tx_wr_q   <= 1'b1;
          end
        end
        StLoad: begin
          state_q <= StWait;
          tx_wr_q <= 1'b0;
        end
        StWait: begin
          if (tx_done_i) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          tx_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_wr_o   = tx_wr_q;

endmodule

// File: tb/tb_uart_fifo_io.sv
// Scoreboard bench for uart_fifo_io: queue-based reference model, randomized RX/CPU traffic.
module tb_uart_fifo_io;

  localparam int          Depth = 16;
  localparam logic [15:0] Base  = 16'hFF10;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] addr_i;
  logic        we_i, re_i;
  logic [7:0]  bus_di_i, bus_do_o;
  logic        sel_o;
  logic [7:0]  tx_data_o;
  logic        tx_wr_o, tx_done_i;
  logic [7:0]  rx_data_i;
  logic        rx_done_i;
`ifdef UART_FIFO_IRQ_EN
  logic        irq_o;
`endif

  uart_fifo_io dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .re_i      (re_i),
    .bus_di_i  (bus_di_i),
    .bus_do_o  (bus_do_o),
    .sel_o     (sel_o),
    .tx_data_o (tx_data_o),
    .tx_wr_o   (tx_wr_o),
    .tx_done_i (tx_done_i),
    .rx_data_i (rx_data_i),
    .rx_done_i (rx_done_i)
`ifdef UART_FIFO_IRQ_EN
    ,
    .irq_o     (irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int tx_pulses = 0;

  // Scoreboard queues: expected {sel, bus_do} per read strobe, expected byte per tx_wr.
  logic [8:0] exp_rd_q[$];
  logic [7:0] exp_tx_q[$];

  // Reference model state.
  logic [7:0] rx_m[$];
  bit         rx_ovr_m, tx_ovf_m, tx_en_m;
  int         tx_cnt_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares whenever the DUT presents a read result or a transmit request.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (re_i) begin
        if (exp_rd_q.size() == 0) check("read_unexpected", {sel_o, bus_do_o}, 9'h1ff);
        else check("read_data", {23'd0, sel_o, bus_do_o}, {23'd0, exp_rd_q.pop_front()});
      end
      if (tx_wr_o) begin
        tx_pulses++;
        if (exp_tx_q.size() == 0) check("tx_unexpected", tx_data_o, 32'h100);
        else check("tx_data", tx_data_o, exp_tx_q.pop_front());
      end
    end
  end

  // UART core stand-in: tx_done pulse 20 cycles after each tx_wr.
  initial begin : uart_core
    int cnt;
    cnt = 0;
    tx_done_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      tx_done_i = 1'b0;
      if (rst_ni !== 1'b1) cnt = 0;
      else if (tx_wr_o) cnt = 20;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done_i = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] status_m(input bit busy);
    return {1'b0, busy, rx_ovr_m, tx_ovf_m, rx_m.size() == Depth, rx_m.size() == 0,
            tx_cnt_m == Depth, tx_cnt_m == 0};
  endfunction

  function automatic logic [7:0] reg_m(input logic [1:0] off);
    case (off)
      2'd0:    return (rx_m.size() != 0) ? rx_m[0] : 8'h00;
      2'd1:    return status_m(1'b0);
      2'd2:    return {7'd0, tx_en_m};
      default: return 8'(rx_m.size());
    endcase
  endfunction

  task automatic model_reset();
    rx_m.delete();
    rx_ovr_m = 0;
    tx_ovf_m = 0;
    tx_en_m  = 1;
    tx_cnt_m = 0;
  endtask

  task automatic drive(input bit we, input bit re, input logic [15:0] a, input logic [7:0] di,
                       input bit rxd, input logic [7:0] rxb);
    addr_i    = a;
    we_i      = we;
    re_i      = re;
    bus_di_i  = di;
    rx_done_i = rxd;
    rx_data_i = rxb;
    @(posedge clk_i);
    #1;
    we_i      = 1'b0;
    re_i      = 1'b0;
    rx_done_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [7:0] d);
    case (off)
      2'd0: begin
        if (tx_en_m) exp_tx_q.push_back(d);
        else if (tx_cnt_m < Depth) begin
          exp_tx_q.push_back(d);
          tx_cnt_m++;
        end else tx_ovf_m = 1;
      end
      2'd1: begin
        if (d[4]) tx_ovf_m = 0;
        if (d[5]) rx_ovr_m = 0;
      end
      2'd2: begin
        tx_en_m = d[0];
        if (d[1]) rx_m.delete();
      end
      default: ;
    endcase
    drive(1'b1, 1'b0, Base + {14'd0, off}, d, 1'b0, 8'h00);
  endtask

  task automatic rd_exp(input logic [1:0] off, input logic [7:0] exp);
    exp_rd_q.push_back({1'b1, exp});
    drive(1'b0, 1'b1, Base + {14'd0, off}, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] off);
    logic [7:0] e;
    e = reg_m(off);
    if (off == 2'd0 && rx_m.size() != 0) void'(rx_m.pop_front());
    rd_exp(off, e);
  endtask

  task automatic rd_outside(input logic [15:0] a);
    exp_rd_q.push_back(9'h000);
    drive(1'b0, 1'b1, a, 8'h00, 1'b0, 8'h00);
  endtask

  // One cycle of optional DATA read plus optional received byte.
  task automatic rx_rd(input bit do_rd, input bit do_rx, input logic [7:0] b);
    if (do_rd) begin
      exp_rd_q.push_back({1'b1, (rx_m.size() != 0) ? rx_m[0] : 8'h00});
      if (rx_m.size() != 0) void'(rx_m.pop_front());
    end
    if (do_rx) begin
      if (rx_m.size() < Depth) rx_m.push_back(b);
      else rx_ovr_m = 1;
    end
    drive(1'b0, do_rd, Base, 8'h00, do_rx, b);
  endtask

  task automatic wait_tx(input int n);
    int i;
    i = 0;
    while (tx_pulses < n && i < 3000) begin
      @(posedge clk_i);
      #1;
      i++;
    end
    check("tx_pulse_count", tx_pulses, n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  initial begin
    int base_pulses;
    rst_ni = 1'b0;
    addr_i = 16'h0000;
    we_i = 1'b0;
    re_i = 1'b0;
    bus_di_i = 8'h00;
    rx_done_i = 1'b0;
    rx_data_i = 8'h00;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle(1);

    // Reset state.
    check("tx_wr_reset", tx_wr_o, 0);
    check("tx_data_reset", tx_data_o, 0);
    rd(2'd1);
    rd(2'd2);
    rd(2'd3);
    rd(2'd0);
    rd_outside(16'hFF14);
    rd_outside(16'hFF0F);

    // Ordered transmit: 'A','B','C' then random bytes.
    wr(2'd0, 8'h41);
    wr(2'd0, 8'h42);
    wr(2'd0, 8'h43);
    for (int i = 0; i < 5; i++) wr(2'd0, 8'($urandom));
    wait_tx(8);
    idle(40);
    rd(2'd1);

    // TX disabled: fill past capacity, overflow flag, clear it, then drain.
    wr(2'd2, 8'h00);
    for (int i = 0; i < Depth + 1; i++) wr(2'd0, 8'($urandom));
    rd(2'd1);
    idle(30);
    check("no_tx_when_disabled", tx_pulses, 8);
    wr(2'd1, 8'h10);
    rd(2'd1);
    wr(2'd2, 8'h01);
    wait_tx(8 + Depth);
    idle(40);
    tx_cnt_m = 0;
    rd(2'd1);

    // RX overrun: Depth+2 bytes with no reads.
    for (int i = 0; i < Depth + 2; i++) rx_rd(1'b0, 1'b1, 8'($urandom));
    rd(2'd3);
    rd(2'd1);
    wr(2'd1, 8'h20);
    rd(2'd1);

    // Full RX with same-cycle pop and push: both succeed, no overrun.
    rx_rd(1'b1, 1'b1, 8'($urandom));
    rd(2'd3);
    rd(2'd1);
    for (int i = 0; i < Depth; i++) rd(2'd0);
    rd(2'd0);
    rd(2'd3);

    // Flush with 5 queued and a byte arriving in the same cycle.
    for (int i = 0; i < 5; i++) rx_rd(1'b0, 1'b1, 8'($urandom));
    rd(2'd3);
    rx_m.delete();
    drive(1'b1, 1'b0, Base + 16'd2, 8'h03, 1'b1, 8'($urandom));
    rd(2'd3);
    rd(2'd1);

    // Randomized RX/CPU traffic against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 10))
        0, 1, 2, 3: rx_rd(1'($urandom), 1'b1, 8'($urandom));
        4, 5, 6:    rd(2'd0);
        7:          rd(2'd3);
        8:          rd(2'd1);
        9:          wr(2'd1, 8'($urandom) & 8'h30);
        default:    if ($urandom_range(0, 3) == 0) wr(2'd2, 8'h03);
      endcase
    end

    // Reset while the FSM waits for tx_done.
    base_pulses = tx_pulses;
    wr(2'd0, 8'($urandom));
    wait_tx(base_pulses + 1);
    idle(3);
    rd_exp(2'd1, status_m(1'b1));
    rst_ni = 1'b0;
    #2;
    check("tx_wr_in_reset", tx_wr_o, 0);
    idle(2);
    rst_ni = 1'b1;
    model_reset();
    idle(1);
    rd(2'd1);
    rd(2'd2);
    rd(2'd3);
    idle(30);
    check("no_tx_after_reset", tx_pulses, base_pulses + 1);

`ifdef UART_FIFO_IRQ_EN
    wr(2'd2, 8'h05);
    idle(1);
    check("irq_idle", irq_o, 0);
    rx_rd(1'b0, 1'b1, 8'h5a);
    idle(1);
    check("irq_rx", irq_o, 1);
`endif

    idle(2);
    check("rd_queue_drained", exp_rd_q.size(), 0);
    check("tx_queue_drained", exp_tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
